// File: rtl/timer_pkg.sv
// Shared definitions for blocks that program the peripheral Timer:
// register offsets, CONTROL bit positions and the scheduler state encoding.
package timer_pkg;

    localparam logic [31:0] TIM_CTRL = 32'h0000_0000;
    localparam logic [31:0] TIM_CNT  = 32'h0000_0004;
    localparam logic [31:0] TIM_CMP  = 32'h0000_0008;
    localparam logic [31:0] TIM_PSC  = 32'h0000_000C;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;
    localparam int CTRL_RST_BIT = 2;
    localparam int CTRL_OVF_BIT = 3;

    // ResetTimer | GenerateInterrupt | EnableTimer
    localparam logic [31:0] CTRL_START_DEF = (32'd1 << CTRL_EN_BIT)
                                           | (32'd1 << CTRL_IRQ_BIT)
                                           | (32'd1 << CTRL_RST_BIT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_CMP   = 3'd1,
        ST_WR_CTRL  = 3'd2,
        ST_WAIT_IRQ = 3'd3,
        ST_CLR      = 3'd4,
        ST_DONE     = 3'd5
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: returns the first set request strictly after last_grant,
// wrapping around; last_grant itself is considered last.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int W = $clog2(N);

    always_comb begin
        int          idx;
        logic [W-1:0] idx_w;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        idx_w     = '0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int off = N; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = W'(idx);
            if (req[idx_w]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx_w;
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one peripheral Timer between NUM_REQ one-shot delay requesters:
// latches requests, grants round-robin, programs the Timer and pulses done.
//
// state    | meaning
// IDLE     | no owner; pick next pending requester
// WR_CMP   | writing delay to COMPARE
// WR_CTRL  | writing CTRL_START to CONTROL
// WAIT_IRQ | Timer running; wait for irq or cancel
// CLR      | writing CTRL_STOP to CONTROL
// DONE     | pulse done for the owner
module timer_scheduler
    import timer_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter logic [31:0] CTRL_START = CTRL_START_DEF,
    parameter logic [31:0] CTRL_STOP  = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_delay,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         cancel,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [31:0]                tim_address,
    output logic                       tim_wr_en,
    output logic [31:0]                tim_wr_data,
    input  logic                       tim_irq
);

    localparam int GW = $clog2(NUM_REQ);

    sched_state_e      state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [31:0]        dly_q [NUM_REQ];
    logic [31:0]        dly_d [NUM_REQ];
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic               abort_q, abort_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] granted_mask;
    logic [NUM_REQ-1:0] cancel_eff;
    logic [NUM_REQ-1:0] arb_req;
    logic               cancel_grant;
    logic               arb_valid;
    logic [GW-1:0]      arb_id;

    // A queued request cancelled on the same edge it would win must not be granted.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .gnt_valid  (arb_valid),
        .gnt_id     (arb_id)
    );

    always_comb begin
        granted_mask = '0;
        if (state_q != ST_IDLE) begin
            granted_mask[grant_q] = 1'b1;
        end
        accept       = req_valid & ~pending_q;
        cancel_eff   = cancel & pending_q & ~granted_mask;
        arb_req      = pending_q & ~cancel_eff;
        cancel_grant = (state_q != ST_IDLE) && cancel[grant_q];
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = (pending_q & ~cancel_eff) | accept;
        dly_d        = dly_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        abort_d      = abort_q;
        done_d       = '0;
        wr_en_d      = 1'b0;
        addr_d       = '0;
        wdata_d      = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                dly_d[i] = req_delay[i*32 +: 32];
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (arb_valid) begin
                    grant_d      = arb_id;
                    last_grant_d = arb_id;
                    if (dly_q[arb_id] == 32'd0) begin
                        state_d        = ST_DONE;
                        done_d[arb_id] = 1'b1;
                    end else begin
                        state_d = ST_WR_CMP;
                        wr_en_d = 1'b1;
                        addr_d  = TIM_CMP;
                        wdata_d = dly_q[arb_id];
                    end
                end
            end
            ST_WR_CMP: begin
                abort_d = abort_q | cancel_grant;
                state_d = ST_WR_CTRL;
                wr_en_d = 1'b1;
                addr_d  = TIM_CTRL;
                wdata_d = CTRL_START;
            end
            ST_WR_CTRL: begin
                abort_d = abort_q | cancel_grant;
                state_d = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (abort_q || cancel_grant || tim_irq) begin
                    abort_d = abort_q | cancel_grant;
                    state_d = ST_CLR;
                    wr_en_d = 1'b1;
                    addr_d  = TIM_CTRL;
                    wdata_d = CTRL_STOP;
                end
            end
            ST_CLR: begin
                if (abort_q) begin
                    state_d            = ST_IDLE;
                    pending_d[grant_q] = 1'b0;
                end else begin
                    state_d         = ST_DONE;
                    done_d[grant_q] = 1'b1;
                end
            end
            ST_DONE: begin
                state_d            = ST_IDLE;
                pending_d[grant_q] = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                dly_q[i] <= '0;
            end
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            abort_q      <= 1'b0;
            done_q       <= '0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            dly_q        <= dly_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            abort_q      <= abort_d;
            done_q       <= done_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign req_ready   = ~pending_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;
    assign tim_wr_en   = wr_en_q;
    assign tim_address = addr_q;
    assign tim_wr_data = wdata_q;

endmodule
